udp_order_parser: RTL and testbench

Receive-side framing stage between the UDP MAC RX AXI-Stream and the engine input FIFO of `trading_system_top`. It strips the 42-byte Ethernet/IPv4/UDP header and optionally filters on destination IP and source port. It decodes the 3-byte opcode, reassembles big-endian 32-bit order words into FIFO writes, and raises a dump request for `OP_DUMP` frames. All logic runs in the `clk_udp` domain.

---
 rtl/udp_order_parser_if.sv | 10 +
 rtl/udp_order_parser.sv | 145 ++++++++++++++
 tb/tb_udp_order_parser.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/udp_order_parser_if.sv
// Receive byte stream from the UDP MAC. There is no tready because the parser
// always accepts.
interface udp_order_parser_if;
  logic [7:0] rx_axis_tdata;
  logic       rx_axis_tvalid;
  logic       rx_axis_tlast;

  modport master (output rx_axis_tdata, output rx_axis_tvalid, output rx_axis_tlast);
  modport slave  (input  rx_axis_tdata, input  rx_axis_tvalid, input  rx_axis_tlast);
endinterface

// File: rtl/udp_order_parser.sv
// Strips the Ethernet/IPv4/UDP header, decodes the opcode, and turns big-endian
// order words into engine FIFO writes. Dump frames raise a one-cycle request.
//   state  | meaning
//   S_HDR  | skipping header bytes, optional IP/port filter
//   S_OP   | collecting the 3-byte opcode
//   S_PAY  | assembling 32-bit order words
//   S_DUMP | dump frame, waiting for tlast
//   S_DROP | rejected frame, waiting for tlast
module udp_order_parser #(
  parameter int          HDR_BYTES = 42,
  parameter bit          FILTER_EN = 1'b0,
  parameter logic [31:0] DEST_IP   = 32'hC0A80132,
  parameter logic [15:0] SRC_PORT  = 16'd55555,
  parameter logic [23:0] OP_MARKET = 24'hFED000,
  parameter logic [23:0] OP_DUMP   = 24'hF0E0D0
) (
  input  logic                clk_udp,
  input  logic                rst_udp,
  udp_order_parser_if.slave   rx,
  output logic [31:0]         o_order_data,
  output logic                o_order_valid,
  input  logic                i_fifo_full,
  output logic                o_dump_req,
  output logic                o_frame_ok,
  output logic [15:0]         o_frame_cnt,
  output logic [15:0]         o_drop_cnt,
  output logic [15:0]         o_ovf_cnt
);

  typedef enum logic [2:0] {S_HDR, S_OP, S_PAY, S_DUMP, S_DROP} state_t;

  localparam logic [5:0] HDR_LAST = 6'(HDR_BYTES - 1);

  state_t      state, state_nxt;
  logic [5:0]  byte_cnt;
  logic        bad;
  logic [1:0]  lane;
  logic [15:0] op_sr;
  logic [23:0] asm_sr;

  logic        beat;
  logic        hdr_chk, hdr_mis;
  logic [7:0]  hdr_exp;
  logic        word_done, end_ok, end_dump, end_drop;

  assign beat = rx.rx_axis_tvalid;

  // Header bytes 30..35 carry destination IP and UDP source port.
  always_comb begin
    hdr_chk = 1'b0;
    hdr_exp = 8'h00;
    case (byte_cnt)
      6'd30: begin hdr_chk = 1'b1; hdr_exp = DEST_IP[31:24]; end
      6'd31: begin hdr_chk = 1'b1; hdr_exp = DEST_IP[23:16]; end
      6'd32: begin hdr_chk = 1'b1; hdr_exp = DEST_IP[15:8];  end
      6'd33: begin hdr_chk = 1'b1; hdr_exp = DEST_IP[7:0];   end
      6'd34: begin hdr_chk = 1'b1; hdr_exp = SRC_PORT[15:8]; end
      6'd35: begin hdr_chk = 1'b1; hdr_exp = SRC_PORT[7:0];  end
      default: ;
    endcase
    hdr_mis = FILTER_EN && hdr_chk && (rx.rx_axis_tdata != hdr_exp);
  end

  always_comb begin
    state_nxt = state;
    word_done = 1'b0;
    end_ok    = 1'b0;
    end_dump  = 1'b0;
    end_drop  = 1'b0;
    if (beat) begin
      case (state)
        S_HDR:
          if (byte_cnt == HDR_LAST) state_nxt = (bad || hdr_mis) ? S_DROP : S_OP;
        S_OP:
          if (lane == 2'd2) begin
            if ({op_sr, rx.rx_axis_tdata} == OP_MARKET)    state_nxt = S_PAY;
            else if ({op_sr, rx.rx_axis_tdata} == OP_DUMP) state_nxt = S_DUMP;
            else                                           state_nxt = S_DROP;
          end
        S_PAY:   word_done = (lane == 2'd3);
        default: ;
      endcase
      if (rx.rx_axis_tlast) begin
        state_nxt = S_HDR;
        case (state)
          S_PAY:   end_ok = 1'b1;
          S_DUMP:  begin end_ok = 1'b1; end_dump = 1'b1; end
          default: end_drop = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk_udp or posedge rst_udp) begin
    if (rst_udp) begin
      state         <= S_HDR;
      byte_cnt      <= '0;
      bad           <= 1'b0;
      lane          <= '0;
      op_sr         <= '0;
      asm_sr        <= '0;
      o_order_data  <= '0;
      o_order_valid <= 1'b0;
      o_dump_req    <= 1'b0;
      o_frame_ok    <= 1'b0;
      o_frame_cnt   <= '0;
      o_drop_cnt    <= '0;
      o_ovf_cnt     <= '0;
    end else begin
      state         <= state_nxt;
      o_order_valid <= word_done && !i_fifo_full;
      o_dump_req    <= end_dump;
      o_frame_ok    <= end_ok;
      if (beat) begin
        case (state)
          S_HDR: begin
            byte_cnt <= byte_cnt + 6'd1;
            if (hdr_mis) bad <= 1'b1;
          end
          S_OP: begin
            op_sr <= {op_sr[7:0], rx.rx_axis_tdata};
            lane  <= (lane == 2'd2) ? 2'd0 : lane + 2'd1;
          end
          S_PAY: begin
            asm_sr <= {asm_sr[15:0], rx.rx_axis_tdata};
            lane   <= lane + 2'd1;
          end
          default: ;
        endcase
        if (rx.rx_axis_tlast) begin
          byte_cnt <= '0;
          bad      <= 1'b0;
          lane     <= '0;
        end
      end
      if (word_done) begin
        if (!i_fifo_full) o_order_data <= {asm_sr, rx.rx_axis_tdata};
        else              o_ovf_cnt    <= o_ovf_cnt + 16'd1;
      end
      if (end_ok)   o_frame_cnt <= o_frame_cnt + 16'd1;
      if (end_drop) o_drop_cnt  <= o_drop_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_udp_order_parser.sv
// Directed bench: one unfiltered and one filtered parser share the same byte stream.
module tb_udp_order_parser;
  logic clk_udp = 1'b0;
  logic rst_udp = 1'b1;
  logic i_fifo_full = 1'b0;
  always #4 clk_udp = ~clk_udp;

  udp_order_parser_if rx_if();

  logic [31:0] o0_order_data, o1_order_data;
  logic        o0_order_valid, o1_order_valid, o0_dump_req, o1_dump_req, o0_frame_ok, o1_frame_ok;
  logic [15:0] o0_frame_cnt, o1_frame_cnt, o0_drop_cnt, o1_drop_cnt, o0_ovf_cnt, o1_ovf_cnt;

  udp_order_parser #(.FILTER_EN(1'b0)) dut0 (
    .clk_udp(clk_udp), .rst_udp(rst_udp), .rx(rx_if),
    .o_order_data(o0_order_data), .o_order_valid(o0_order_valid), .i_fifo_full(i_fifo_full),
    .o_dump_req(o0_dump_req), .o_frame_ok(o0_frame_ok), .o_frame_cnt(o0_frame_cnt),
    .o_drop_cnt(o0_drop_cnt), .o_ovf_cnt(o0_ovf_cnt));

  udp_order_parser #(.FILTER_EN(1'b1)) dut1 (
    .clk_udp(clk_udp), .rst_udp(rst_udp), .rx(rx_if),
    .o_order_data(o1_order_data), .o_order_valid(o1_order_valid), .i_fifo_full(i_fifo_full),
    .o_dump_req(o1_dump_req), .o_frame_ok(o1_frame_ok), .o_frame_cnt(o1_frame_cnt),
    .o_drop_cnt(o1_drop_cnt), .o_ovf_cnt(o1_ovf_cnt));

  int checks = 0;
  int errors = 0;
  int wr0 = 0, wr1 = 0;
  logic [31:0] last0 = '0, last1 = '0;
  logic [7:0]  frm[$];

  always @(negedge clk_udp) begin
    if (o0_order_valid) begin wr0++; last0 = o0_order_data; end
    if (o1_order_valid) begin wr1++; last1 = o1_order_data; end
  end

  task automatic plain_hdr();
    frm.delete();
    for (int i = 0; i < 42; i++) frm.push_back(8'hAA);
  endtask

  task automatic ip_hdr(input logic [7:0] b33, input logic [7:0] b35);
    plain_hdr();
    frm[30] = 8'hC0; frm[31] = 8'hA8; frm[32] = 8'h01; frm[33] = b33;
    frm[34] = 8'hD9; frm[35] = b35;
  endtask

  task automatic push3(input logic [23:0] v);
    frm.push_back(v[23:16]); frm.push_back(v[15:8]); frm.push_back(v[7:0]);
  endtask

  task automatic push4(input logic [31:0] w);
    frm.push_back(w[31:24]); frm.push_back(w[23:16]); frm.push_back(w[15:8]); frm.push_back(w[7:0]);
  endtask

  task automatic send_frame(input int full_lo, input int full_hi, input bit with_last);
    for (int i = 0; i < frm.size(); i++) begin
      rx_if.rx_axis_tdata  = frm[i];
      rx_if.rx_axis_tvalid = 1'b1;
      rx_if.rx_axis_tlast  = with_last && (i == frm.size() - 1);
      i_fifo_full          = (i >= full_lo) && (i <= full_hi);
      @(posedge clk_udp); #1;
    end
    rx_if.rx_axis_tvalid = 1'b0;
    rx_if.rx_axis_tlast  = 1'b0;
    i_fifo_full          = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_udp); #1; end
  endtask

  task automatic do_reset();
    rx_if.rx_axis_tvalid = 1'b0;
    rx_if.rx_axis_tlast  = 1'b0;
    rx_if.rx_axis_tdata  = 8'h00;
    i_fifo_full = 1'b0;
    rst_udp = 1'b1;
    repeat (2) @(posedge clk_udp);
    #1 rst_udp = 1'b0;
    idle(1);
  endtask

  task automatic test_reset();
    rx_if.rx_axis_tvalid = 1'b0; rx_if.rx_axis_tlast = 1'b0; rx_if.rx_axis_tdata = 8'h00;
    rst_udp = 1'b1;
    repeat (2) @(posedge clk_udp);
    #1;
    checks++; if (o0_order_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", o0_order_data); end
    checks++; if ({o0_order_valid, o0_dump_req, o0_frame_ok} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {o0_order_valid, o0_dump_req, o0_frame_ok}); end
    checks++; if ({o0_frame_cnt, o0_drop_cnt, o0_ovf_cnt} !== 48'h0) begin errors++; $display("FAIL reset_cnts got %h exp 0", {o0_frame_cnt, o0_drop_cnt, o0_ovf_cnt}); end
    checks++; if ({o1_frame_cnt, o1_drop_cnt, o1_ovf_cnt} !== 48'h0) begin errors++; $display("FAIL reset_cnts_f got %h exp 0", {o1_frame_cnt, o1_drop_cnt, o1_ovf_cnt}); end
    #1 rst_udp = 1'b0;
    idle(1);
  endtask

  task automatic test_single_order();
    plain_hdr(); push3(24'hFED000); push4(32'h0069000A);
    send_frame(-1, -1, 1'b1);
    checks++; if (o0_order_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", o0_order_valid); end
    checks++; if (o0_order_data !== 32'h0069000A) begin errors++; $display("FAIL single_data got %h exp 0069000a", o0_order_data); end
    checks++; if (o0_frame_ok !== 1'b1) begin errors++; $display("FAIL single_ok got %b exp 1", o0_frame_ok); end
    checks++; if (o0_frame_cnt !== 16'd1) begin errors++; $display("FAIL single_fcnt got %0d exp 1", o0_frame_cnt); end
    idle(1);
    checks++; if ({o0_order_valid, o0_frame_ok} !== 2'b00) begin errors++; $display("FAIL single_pulse_len got %b exp 00", {o0_order_valid, o0_frame_ok}); end
    checks++; if (o0_order_data !== 32'h0069000A) begin errors++; $display("FAIL single_hold got %h exp 0069000a", o0_order_data); end
    checks++; if (wr0 !== 1) begin errors++; $display("FAIL single_wr got %0d exp 1", wr0); end
    checks++; if (o1_drop_cnt !== 16'd1) begin errors++; $display("FAIL single_filt_drop got %0d exp 1", o1_drop_cnt); end
  endtask

  task automatic test_dump();
    plain_hdr(); push3(24'hF0E0D0); frm.push_back(8'h00);
    send_frame(-1, -1, 1'b1);
    checks++; if ({o0_dump_req, o0_frame_ok} !== 2'b11) begin errors++; $display("FAIL dump_pulse got %b exp 11", {o0_dump_req, o0_frame_ok}); end
    checks++; if (o0_frame_cnt !== 16'd2) begin errors++; $display("FAIL dump_fcnt got %0d exp 2", o0_frame_cnt); end
    idle(1);
    checks++; if (o0_dump_req !== 1'b0) begin errors++; $display("FAIL dump_len got %b exp 0", o0_dump_req); end
    checks++; if (wr0 !== 1) begin errors++; $display("FAIL dump_nowr got %0d exp 1", wr0); end
  endtask

  task automatic test_back_to_back();
    plain_hdr(); push3(24'h123456); push4(32'h00010203);
    send_frame(-1, -1, 1'b1);
    checks++; if (o0_drop_cnt !== 16'd1) begin errors++; $display("FAIL unk_drop got %0d exp 1", o0_drop_cnt); end
    frm.delete(); for (int i = 0; i < 21; i++) frm.push_back(8'h55);
    send_frame(-1, -1, 1'b1);
    checks++; if (o0_drop_cnt !== 16'd2) begin errors++; $display("FAIL runt_drop got %0d exp 2", o0_drop_cnt); end
    plain_hdr(); push3(24'hFED000); push4(32'h005A8014); frm.push_back(8'h11);
    send_frame(-1, -1, 1'b1);
    idle(1);
    checks++; if (o0_frame_cnt !== 16'd3) begin errors++; $display("FAIL b2b_fcnt got %0d exp 3", o0_frame_cnt); end
    checks++; if (wr0 !== 2 || last0 !== 32'h005A8014) begin errors++; $display("FAIL b2b_order got %0d/%h exp 2/005a8014", wr0, last0); end
    checks++; if (o0_drop_cnt !== 16'd2) begin errors++; $display("FAIL b2b_drop got %0d exp 2", o0_drop_cnt); end
  endtask

  task automatic test_overflow();
    int w0;
    do_reset();
    w0 = wr0;
    plain_hdr(); push3(24'hFED000); push4(32'h005A8014); push4(32'h0069000A); frm.push_back(8'h00);
    send_frame(52, 52, 1'b1);
    idle(1);
    checks++; if (wr0 - w0 !== 1 || last0 !== 32'h005A8014) begin errors++; $display("FAIL ovf_wr got %0d/%h exp 1/005a8014", wr0 - w0, last0); end
    checks++; if (o0_ovf_cnt !== 16'd1) begin errors++; $display("FAIL ovf_cnt got %0d exp 1", o0_ovf_cnt); end
    checks++; if (o0_order_data !== 32'h005A8014) begin errors++; $display("FAIL ovf_hold got %h exp 005a8014", o0_order_data); end
    send_frame(45, 47, 1'b1);
    idle(1);
    checks++; if (wr0 - w0 !== 3 || last0 !== 32'h0069000A) begin errors++; $display("FAIL full_notlane3 got %0d/%h exp 3/0069000a", wr0 - w0, last0); end
    checks++; if (o0_ovf_cnt !== 16'd1 || o0_frame_cnt !== 16'd2) begin errors++; $display("FAIL full_cnts got %0d/%0d exp 1/2", o0_ovf_cnt, o0_frame_cnt); end
  endtask

  task automatic test_filter();
    int w1;
    do_reset();
    w1 = wr1;
    ip_hdr(8'h33, 8'h03); push3(24'hFED000); push4(32'h0069000A); frm.push_back(8'h00);
    send_frame(-1, -1, 1'b1);
    idle(1);
    checks++; if (o1_drop_cnt !== 16'd1 || wr1 !== w1) begin errors++; $display("FAIL filt_ip got %0d/%0d exp 1/%0d", o1_drop_cnt, wr1, w1); end
    checks++; if (o0_frame_cnt !== 16'd1) begin errors++; $display("FAIL nofilt_accept got %0d exp 1", o0_frame_cnt); end
    ip_hdr(8'h32, 8'h04); push3(24'hFED000); push4(32'h0069000A); frm.push_back(8'h00);
    send_frame(-1, -1, 1'b1);
    idle(1);
    checks++; if (o1_drop_cnt !== 16'd2 || wr1 !== w1) begin errors++; $display("FAIL filt_port got %0d/%0d exp 2/%0d", o1_drop_cnt, wr1, w1); end
    ip_hdr(8'h32, 8'h03); push3(24'hFED000); push4(32'h005A8014); push4(32'h0069000A); frm.push_back(8'h00);
    send_frame(-1, -1, 1'b1);
    idle(1);
    checks++; if (o1_frame_cnt !== 16'd1) begin errors++; $display("FAIL filt_ok_fcnt got %0d exp 1", o1_frame_cnt); end
    checks++; if (wr1 - w1 !== 2 || last1 !== 32'h0069000A) begin errors++; $display("FAIL filt_ok_wr got %0d/%h exp 2/0069000a", wr1 - w1, last1); end
  endtask

  task automatic test_reset_mid_payload();
    int w0;
    plain_hdr(); push3(24'hFED000); frm.push_back(8'h00); frm.push_back(8'h5A);
    send_frame(-1, -1, 1'b0);
    rst_udp = 1'b1;
    #1;
    checks++; if ({o0_order_data, o0_order_valid, o0_dump_req, o0_frame_ok} !== 35'h0) begin errors++; $display("FAIL midrst_out got %h exp 0", {o0_order_data, o0_order_valid, o0_dump_req, o0_frame_ok}); end
    checks++; if ({o0_frame_cnt, o0_drop_cnt, o0_ovf_cnt, o1_drop_cnt} !== 64'h0) begin errors++; $display("FAIL midrst_cnts got %h exp 0", {o0_frame_cnt, o0_drop_cnt, o0_ovf_cnt, o1_drop_cnt}); end
    @(posedge clk_udp); #1 rst_udp = 1'b0;
    idle(1);
    w0 = wr0;
    plain_hdr(); push3(24'hFED000); push4(32'h12348005); frm.push_back(8'h00);
    send_frame(-1, -1, 1'b1);
    idle(1);
    checks++; if (o0_frame_cnt !== 16'd1 || o0_drop_cnt !== 16'd0) begin errors++; $display("FAIL midrst_next got %0d/%0d exp 1/0", o0_frame_cnt, o0_drop_cnt); end
    checks++; if (wr0 - w0 !== 1 || last0 !== 32'h12348005) begin errors++; $display("FAIL midrst_order got %0d/%h exp 1/12348005", wr0 - w0, last0); end
  endtask

  initial begin
    test_reset();
    test_single_order();
    test_dump();
    test_back_to_back();
    test_overflow();
    test_filter();
    test_reset_mid_payload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
